// File: rtl/risc_controller_pkg.sv
// Shared RISC CPU definitions: opcode and phase encodings plus default field widths.
// Imported by the controller, its opcode decoder, the ALU and the testbench.
package risc_controller_pkg;

    localparam int DEF_OPCODE_WIDTH = 3;
    localparam int DEF_PHASE_WIDTH  = 3;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_e;

endpackage

// File: rtl/risc_controller_op_decode.sv
// Combinational opcode classifier feeding the controller's output decode.
// Zero latency; no state, so no backpressure.
module risc_op_decode
    import risc_controller_pkg::*;
(
    input  logic [2:0] opcode,
    output logic       is_hlt,
    output logic       is_skz,
    output logic       is_jmp,
    output logic       is_sto,
    output logic       is_aluop
);

    always_comb begin
        is_hlt   = (opcode == HLT);
        is_skz   = (opcode == SKZ);
        is_jmp   = (opcode == JMP);
        is_sto   = (opcode == STO);
        is_aluop = (opcode == ADD) || (opcode == AND) ||
                   (opcode == XOR) || (opcode == LDA);
    end

endmodule

// File: rtl/risc_controller.sv
// 8-phase RISC instruction sequencer: registered phase + sticky halt, combinational strobe decode.
// Strobes are qualified by ena so a stall never repeats one; CTRL_SINGLE_STEP_EN adds a step gate on phase 0.
module risc_controller
    import risc_controller_pkg::*;
#(
    parameter int OPCODE_WIDTH = DEF_OPCODE_WIDTH,
    parameter int PHASE_WIDTH  = DEF_PHASE_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    zero,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic                    step,
`endif
    output logic                    sel,
    output logic                    rd,
    output logic                    wr,
    output logic                    data_e,
    output logic                    ld_ir,
    output logic                    inc_pc,
    output logic                    ld_pc,
    output logic                    ld_ac,
    output logic                    halt,
    output logic [PHASE_WIDTH-1:0]  phase
);

    phase_e phase_q, phase_nxt;
    logic   halted_q, halted_nxt;
    logic   advance;
    logic   is_hlt, is_skz, is_jmp, is_sto, is_aluop;

    risc_op_decode u_op_decode (
        .opcode   (opcode),
        .is_hlt   (is_hlt),
        .is_skz   (is_skz),
        .is_jmp   (is_jmp),
        .is_sto   (is_sto),
        .is_aluop (is_aluop)
    );

`ifdef CTRL_SINGLE_STEP_EN
    assign advance = ena && ((phase_q != INST_ADDR) || step);
`else
    assign advance = ena;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_nxt;
            halted_q <= halted_nxt;
        end
    end

    always_comb begin
        phase_nxt  = phase_q;
        halted_nxt = halted_q;
        sel        = 1'b0;
        rd         = 1'b0;
        wr         = 1'b0;
        data_e     = 1'b0;
        ld_ir      = 1'b0;
        inc_pc     = 1'b0;
        ld_pc      = 1'b0;
        ld_ac      = 1'b0;
        halt       = 1'b0;

        // Reset overrides the decode so an aborted instruction emits nothing.
        if (rst) begin
            sel = 1'b1;
        end else if (halted_q) begin
            halt = 1'b1;
        end else begin
            if (advance) phase_nxt = phase_e'(phase_q + 3'd1);
            case (phase_q)
                INST_ADDR: sel = 1'b1;
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = ena;
                end
                OP_ADDR: begin
                    inc_pc = ena;
                    halt   = is_hlt;
                    if (is_hlt && ena) halted_nxt = 1'b1;
                end
                OP_FETCH: rd = is_aluop;
                ALU_OP: begin
                    rd     = is_aluop;
                    inc_pc = is_skz && zero && ena;
                    ld_pc  = is_jmp && ena;
                    data_e = is_sto;
                end
                STORE: begin
                    rd     = is_aluop;
                    inc_pc = is_jmp && ena;
                    ld_pc  = is_jmp && ena;
                    ld_ac  = is_aluop && ena;
                    wr     = is_sto && ena;
                    data_e = is_sto;
                end
                default: ;
            endcase
        end
    end

    assign phase = rst ? INST_ADDR : phase_q;

endmodule
